// File: rtl/commit_stage.sv
// Retirement stage behind the reorder buffer. It updates the retirement alias table,
// frees superseded physical registers, and emits branch-predictor updates, squash and halt.
module commit_stage #(
  parameter int N         = 2,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int XLEN      = 32,
  parameter int CNT_W     = 64
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N-1:0]                      ct_valid_i,
  input  logic [N-1:0]                      ct_success_i,
  input  logic [N-1:0]                      ct_is_store_i,
  input  logic [N-1:0]                      ct_is_branch_i,
  input  logic [N-1:0]                      ct_taken_i,
  input  logic [N-1:0]                      ct_halt_i,
  input  logic [N-1:0]                      ct_illegal_i,
  input  logic [N*$clog2(ARCH_REGS)-1:0]    ct_dest_arn_i,
  input  logic [N*$clog2(PHYS_REGS)-1:0]    ct_dest_prn_i,
  input  logic [N*XLEN-1:0]                 ct_pc_i,
  input  logic [N*XLEN-1:0]                 ct_target_i,
  output logic [N-1:0]                      free_valid_o,
  output logic [N*$clog2(PHYS_REGS)-1:0]    free_prn_o,
  output logic [$clog2(N):0]                store_release_o,
  output logic                              bp_valid_o,
  output logic [XLEN-1:0]                   bp_pc_o,
  output logic                              bp_taken_o,
  output logic [XLEN-1:0]                   bp_target_o,
  output logic                              squash_o,
  output logic [XLEN-1:0]                   redirect_pc_o,
  output logic [ARCH_REGS*$clog2(PHYS_REGS)-1:0] rrat_map_o,
  output logic [CNT_W-1:0]                  retired_cnt_o,
  output logic                              halted_o,
  output logic                              illegal_err_o
);

  localparam int ARN_W = $clog2(ARCH_REGS);
  localparam int PRN_W = $clog2(PHYS_REGS);
  localparam int SR_W  = $clog2(N) + 1;

  // state   | meaning
  // RUN     | lanes accepted normally
  // HALTED  | halt/illegal retired; nothing accepted until reset
  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t                             state_q, state_d;
  logic [ARCH_REGS-1:0][PRN_W-1:0]    rrat_q, rrat_d;
  logic [N-1:0]                       free_valid_q, free_valid_d;
  logic [N-1:0][PRN_W-1:0]            free_prn_q, free_prn_d;
  logic [SR_W-1:0]                    store_q, store_d;
  logic                               bp_valid_q, bp_valid_d;
  logic [XLEN-1:0]                    bp_pc_q, bp_pc_d;
  logic                               bp_taken_q, bp_taken_d;
  logic [XLEN-1:0]                    bp_target_q, bp_target_d;
  logic                               squash_q, squash_d;
  logic [XLEN-1:0]                    redirect_q, redirect_d;
  logic [CNT_W-1:0]                   retired_q, retired_d;
  logic                               illegal_q, illegal_d;

  logic                               alive;
  logic [SR_W-1:0]                    n_acc;
  logic [ARN_W-1:0]                   lane_arn;
  logic [PRN_W-1:0]                   lane_prn;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      for (int a = 0; a < ARCH_REGS; a++) rrat_q[a] <= PRN_W'(a);
      free_valid_q <= '0;
      free_prn_q   <= '0;
      store_q      <= '0;
      bp_valid_q   <= 1'b0;
      bp_pc_q      <= '0;
      bp_taken_q   <= 1'b0;
      bp_target_q  <= '0;
      squash_q     <= 1'b0;
      redirect_q   <= '0;
      retired_q    <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rrat_q       <= rrat_d;
      free_valid_q <= free_valid_d;
      free_prn_q   <= free_prn_d;
      store_q      <= store_d;
      bp_valid_q   <= bp_valid_d;
      bp_pc_q      <= bp_pc_d;
      bp_taken_q   <= bp_taken_d;
      bp_target_q  <= bp_target_d;
      squash_q     <= squash_d;
      redirect_q   <= redirect_d;
      retired_q    <= retired_d;
      illegal_q    <= illegal_d;
    end
  end

  // Lanes are walked oldest first; rrat_d carries same-bundle renames forward so a
  // younger lane writing the same arn frees the older lane's prn.
  always_comb begin
    state_d      = state_q;
    rrat_d       = rrat_q;
    free_valid_d = '0;
    free_prn_d   = '0;
    store_d      = '0;
    bp_valid_d   = 1'b0;
    bp_pc_d      = '0;
    bp_taken_d   = 1'b0;
    bp_target_d  = '0;
    squash_d     = 1'b0;
    redirect_d   = '0;
    illegal_d    = illegal_q;
    alive        = (state_q == ST_RUN);
    n_acc        = '0;
    lane_arn     = '0;
    lane_prn     = '0;

    for (int i = 0; i < N; i++) begin
      lane_arn = ct_dest_arn_i[i*ARN_W +: ARN_W];
      lane_prn = ct_dest_prn_i[i*PRN_W +: PRN_W];
      if (alive && ct_valid_i[i]) begin
        n_acc = n_acc + SR_W'(1);
        if (lane_arn != '0) begin
          free_valid_d[i] = 1'b1;
          free_prn_d[i]   = rrat_d[lane_arn];
          rrat_d[lane_arn] = lane_prn;
        end
        if (ct_is_store_i[i]) store_d = store_d + SR_W'(1);
        if (ct_is_branch_i[i] && !bp_valid_d) begin
          bp_valid_d  = 1'b1;
          bp_pc_d     = ct_pc_i[i*XLEN +: XLEN];
          bp_taken_d  = ct_taken_i[i];
          bp_target_d = ct_target_i[i*XLEN +: XLEN];
        end
        // Halt wins over a mispredict in the same lane: no squash is raised.
        if (ct_halt_i[i] || ct_illegal_i[i]) begin
          state_d   = ST_HALTED;
          illegal_d = ct_illegal_i[i];
          alive     = 1'b0;
        end else if (!ct_success_i[i]) begin
          squash_d   = 1'b1;
          redirect_d = ct_target_i[i*XLEN +: XLEN];
          alive      = 1'b0;
        end
      end else begin
        alive = 1'b0;
      end
    end

    retired_d = retired_q + CNT_W'(n_acc);
  end

  assign free_valid_o    = free_valid_q;
  assign free_prn_o      = free_prn_q;
  assign store_release_o = store_q;
  assign bp_valid_o      = bp_valid_q;
  assign bp_pc_o         = bp_pc_q;
  assign bp_taken_o      = bp_taken_q;
  assign bp_target_o     = bp_target_q;
  assign squash_o        = squash_q;
  assign redirect_pc_o   = redirect_q;
  assign rrat_map_o      = rrat_q;
  assign retired_cnt_o   = retired_q;
  assign halted_o        = (state_q == ST_HALTED);
  assign illegal_err_o   = illegal_q;

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage: each task drives one scenario and checks
// the registered outputs one cycle later against hand-computed values.
module tb_commit_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  ct_valid, ct_success, ct_is_store, ct_is_branch, ct_taken, ct_halt, ct_illegal;
  logic [9:0]  ct_dest_arn;
  logic [11:0] ct_dest_prn;
  logic [63:0] ct_pc, ct_target;
  logic [1:0]  free_valid;
  logic [11:0] free_prn;
  logic [1:0]  store_release;
  logic        bp_valid, bp_taken, squash, halted, illegal_err;
  logic [31:0] bp_pc, bp_target, redirect_pc;
  logic [191:0] rrat_map;
  logic [63:0] retired_cnt;

  int tests_run = 0;
  int failed    = 0;

  commit_stage dut (
    .clock(clock), .reset(reset),
    .ct_valid_i(ct_valid), .ct_success_i(ct_success), .ct_is_store_i(ct_is_store),
    .ct_is_branch_i(ct_is_branch), .ct_taken_i(ct_taken), .ct_halt_i(ct_halt),
    .ct_illegal_i(ct_illegal), .ct_dest_arn_i(ct_dest_arn), .ct_dest_prn_i(ct_dest_prn),
    .ct_pc_i(ct_pc), .ct_target_i(ct_target),
    .free_valid_o(free_valid), .free_prn_o(free_prn), .store_release_o(store_release),
    .bp_valid_o(bp_valid), .bp_pc_o(bp_pc), .bp_taken_o(bp_taken), .bp_target_o(bp_target),
    .squash_o(squash), .redirect_pc_o(redirect_pc), .rrat_map_o(rrat_map),
    .retired_cnt_o(retired_cnt), .halted_o(halted), .illegal_err_o(illegal_err)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0] rrat(input int a);
    return rrat_map[a*6 +: 6];
  endfunction

  function automatic logic [5:0] fprn(input int i);
    return free_prn[i*6 +: 6];
  endfunction

  task automatic clear_inputs();
    ct_valid = '0; ct_success = 2'b11; ct_is_store = '0; ct_is_branch = '0;
    ct_taken = '0; ct_halt = '0; ct_illegal = '0; ct_dest_arn = '0; ct_dest_prn = '0;
    ct_pc = '0; ct_target = '0;
  endtask

  task automatic set_lane(input int i, input logic succ, input logic st, input logic br,
                          input logic tk, input logic hl, input logic il,
                          input logic [4:0] arn, input logic [5:0] prn,
                          input logic [31:0] pc, input logic [31:0] tgt);
    ct_valid[i] = 1'b1; ct_success[i] = succ; ct_is_store[i] = st; ct_is_branch[i] = br;
    ct_taken[i] = tk; ct_halt[i] = hl; ct_illegal[i] = il;
    ct_dest_arn[i*5 +: 5] = arn; ct_dest_prn[i*6 +: 6] = prn;
    ct_pc[i*32 +: 32] = pc; ct_target[i*32 +: 32] = tgt;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) step();
    tests_run++; if (rrat(5) !== 6'd5) begin failed++; $display("FAIL reset_rrat5: got %0d expected 5", rrat(5)); end
    tests_run++; if (halted !== 1'b0) begin failed++; $display("FAIL reset_halted: got %b expected 0", halted); end
    tests_run++; if (retired_cnt !== 64'd0) begin failed++; $display("FAIL reset_retired: got %0d expected 0", retired_cnt); end
    tests_run++; if (free_valid !== 2'b00 || squash !== 1'b0) begin failed++; $display("FAIL reset_outputs: got fv=%b sq=%b expected 00/0", free_valid, squash); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    set_lane(0, 1, 0, 0, 0, 0, 0, 5'd5, 6'd40, 32'h0, 32'h4);
    step();
    tests_run++; if (free_valid !== 2'b01) begin failed++; $display("FAIL basic_fv: got %b expected 01", free_valid); end
    tests_run++; if (fprn(0) !== 6'd5) begin failed++; $display("FAIL basic_fprn: got %0d expected 5", fprn(0)); end
    tests_run++; if (rrat(5) !== 6'd40) begin failed++; $display("FAIL basic_rrat5: got %0d expected 40", rrat(5)); end
    tests_run++; if (retired_cnt !== 64'd1) begin failed++; $display("FAIL basic_retired: got %0d expected 1", retired_cnt); end
  endtask

  task automatic test_waw();
    set_lane(0, 1, 0, 0, 0, 0, 0, 5'd3, 6'd33, 32'h8, 32'hc);
    set_lane(1, 1, 0, 0, 0, 0, 0, 5'd3, 6'd34, 32'hc, 32'h10);
    step();
    tests_run++; if (free_valid !== 2'b11) begin failed++; $display("FAIL waw_fv: got %b expected 11", free_valid); end
    tests_run++; if (fprn(0) !== 6'd3 || fprn(1) !== 6'd33) begin failed++; $display("FAIL waw_fprn: got %0d,%0d expected 3,33", fprn(0), fprn(1)); end
    tests_run++; if (rrat(3) !== 6'd34) begin failed++; $display("FAIL waw_rrat3: got %0d expected 34", rrat(3)); end
    tests_run++; if (retired_cnt !== 64'd3) begin failed++; $display("FAIL waw_retired: got %0d expected 3", retired_cnt); end
  endtask

  task automatic test_mispredict();
    set_lane(0, 0, 0, 1, 1, 0, 0, 5'd7, 6'd41, 32'h10, 32'h1000);
    set_lane(1, 1, 0, 0, 0, 0, 0, 5'd8, 6'd42, 32'h14, 32'h18);
    step();
    tests_run++; if (squash !== 1'b1 || redirect_pc !== 32'h1000) begin failed++; $display("FAIL mis_squash: got sq=%b pc=%h expected 1/1000", squash, redirect_pc); end
    tests_run++; if (retired_cnt !== 64'd4) begin failed++; $display("FAIL mis_retired: got %0d expected 4", retired_cnt); end
    tests_run++; if (rrat(8) !== 6'd8 || rrat(7) !== 6'd41) begin failed++; $display("FAIL mis_rrat: got r8=%0d r7=%0d expected 8/41", rrat(8), rrat(7)); end
    tests_run++; if (free_valid !== 2'b01 || fprn(0) !== 6'd7) begin failed++; $display("FAIL mis_free: got fv=%b p=%0d expected 01/7", free_valid, fprn(0)); end
    // lanes right after a squash are accepted normally
    set_lane(0, 1, 0, 0, 0, 0, 0, 5'd8, 6'd43, 32'h1000, 32'h1004);
    step();
    tests_run++; if (squash !== 1'b0) begin failed++; $display("FAIL post_squash_sq: got %b expected 0", squash); end
    tests_run++; if (rrat(8) !== 6'd43 || fprn(0) !== 6'd8 || retired_cnt !== 64'd5) begin failed++; $display("FAIL post_squash: got r8=%0d p=%0d cnt=%0d expected 43/8/5", rrat(8), fprn(0), retired_cnt); end
  endtask

  task automatic test_gap();
    set_lane(1, 1, 1, 0, 0, 0, 0, 5'd9, 6'd44, 32'h0, 32'h0);
    step();
    tests_run++; if (retired_cnt !== 64'd5 || free_valid !== 2'b00 || store_release !== 2'd0) begin failed++; $display("FAIL gap: got cnt=%0d fv=%b sr=%0d expected 5/00/0", retired_cnt, free_valid, store_release); end
    tests_run++; if (rrat(9) !== 6'd9) begin failed++; $display("FAIL gap_rrat9: got %0d expected 9", rrat(9)); end
  endtask

  task automatic test_arn0_store();
    set_lane(0, 1, 0, 0, 0, 0, 0, 5'd0, 6'd50, 32'h20, 32'h24);
    set_lane(1, 1, 1, 0, 0, 0, 0, 5'd0, 6'd51, 32'h24, 32'h28);
    step();
    tests_run++; if (free_valid !== 2'b00) begin failed++; $display("FAIL arn0_fv: got %b expected 00", free_valid); end
    tests_run++; if (store_release !== 2'd1) begin failed++; $display("FAIL arn0_store: got %0d expected 1", store_release); end
    tests_run++; if (rrat(0) !== 6'd0 || retired_cnt !== 64'd7) begin failed++; $display("FAIL arn0_map: got r0=%0d cnt=%0d expected 0/7", rrat(0), retired_cnt); end
  endtask

  task automatic test_bp_oldest();
    set_lane(0, 1, 1, 1, 0, 0, 0, 5'd0, 6'd0, 32'h40, 32'h44);
    set_lane(1, 1, 1, 1, 1, 0, 0, 5'd0, 6'd0, 32'h48, 32'h80);
    step();
    tests_run++; if (bp_valid !== 1'b1 || bp_pc !== 32'h40 || bp_taken !== 1'b0 || bp_target !== 32'h44) begin failed++; $display("FAIL bp_oldest: got v=%b pc=%h t=%b tg=%h expected 1/40/0/44", bp_valid, bp_pc, bp_taken, bp_target); end
    tests_run++; if (store_release !== 2'd2 || retired_cnt !== 64'd9) begin failed++; $display("FAIL bp_counts: got sr=%0d cnt=%0d expected 2/9", store_release, retired_cnt); end
    step();
    tests_run++; if (bp_valid !== 1'b0) begin failed++; $display("FAIL bp_idle: got %b expected 0", bp_valid); end
  endtask

  task automatic test_halt();
    set_lane(0, 1, 0, 0, 0, 1, 0, 5'd0, 6'd0, 32'h50, 32'h54);
    set_lane(1, 1, 1, 0, 0, 0, 0, 5'd0, 6'd0, 32'h54, 32'h58);
    step();
    tests_run++; if (halted !== 1'b1 || illegal_err !== 1'b0) begin failed++; $display("FAIL halt_flags: got h=%b ie=%b expected 1/0", halted, illegal_err); end
    tests_run++; if (store_release !== 2'd0 || retired_cnt !== 64'd10) begin failed++; $display("FAIL halt_counts: got sr=%0d cnt=%0d expected 0/10", store_release, retired_cnt); end
    set_lane(0, 1, 1, 1, 0, 0, 0, 5'd5, 6'd60, 32'h60, 32'h64);
    set_lane(1, 0, 0, 0, 0, 0, 0, 5'd6, 6'd61, 32'h64, 32'h68);
    step();
    tests_run++; if (free_valid !== 2'b00 || store_release !== 2'd0 || bp_valid !== 1'b0 || squash !== 1'b0) begin failed++; $display("FAIL halted_quiet: got fv=%b sr=%0d bp=%b sq=%b expected all 0", free_valid, store_release, bp_valid, squash); end
    tests_run++; if (retired_cnt !== 64'd10 || rrat(5) !== 6'd40 || halted !== 1'b1) begin failed++; $display("FAIL halted_state: got cnt=%0d r5=%0d h=%b expected 10/40/1", retired_cnt, rrat(5), halted); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++; if (rrat(5) !== 6'd5 || rrat(3) !== 6'd3 || halted !== 1'b0 || retired_cnt !== 64'd0) begin failed++; $display("FAIL halt_reset: got r5=%0d r3=%0d h=%b cnt=%0d expected 5/3/0/0", rrat(5), rrat(3), halted, retired_cnt); end
  endtask

  task automatic test_illegal();
    set_lane(0, 1, 0, 1, 1, 0, 0, 5'd0, 6'd0, 32'h20, 32'h30);
    set_lane(1, 1, 0, 0, 0, 0, 1, 5'd4, 6'd45, 32'h30, 32'h34);
    step();
    tests_run++; if (bp_valid !== 1'b1 || bp_pc !== 32'h20 || bp_taken !== 1'b1 || bp_target !== 32'h30) begin failed++; $display("FAIL ill_bp: got v=%b pc=%h t=%b tg=%h expected 1/20/1/30", bp_valid, bp_pc, bp_taken, bp_target); end
    tests_run++; if (halted !== 1'b1 || illegal_err !== 1'b1) begin failed++; $display("FAIL ill_flags: got h=%b ie=%b expected 1/1", halted, illegal_err); end
    tests_run++; if (retired_cnt !== 64'd2 || rrat(4) !== 6'd45 || fprn(1) !== 6'd4) begin failed++; $display("FAIL ill_commit: got cnt=%0d r4=%0d p1=%0d expected 2/45/4", retired_cnt, rrat(4), fprn(1)); end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    set_lane(0, 0, 1, 1, 1, 0, 0, 5'd5, 6'd60, 32'h70, 32'h74);
    set_lane(1, 1, 1, 0, 0, 0, 0, 5'd6, 6'd61, 32'h74, 32'h78);
    step();
    reset = 1'b0;
    tests_run++; if (rrat(5) !== 6'd5 || rrat(4) !== 6'd4 || retired_cnt !== 64'd0) begin failed++; $display("FAIL midrst_map: got r5=%0d r4=%0d cnt=%0d expected 5/4/0", rrat(5), rrat(4), retired_cnt); end
    tests_run++; if (halted !== 1'b0 || illegal_err !== 1'b0 || free_valid !== 2'b00 || store_release !== 2'd0 || squash !== 1'b0 || bp_valid !== 1'b0) begin failed++; $display("FAIL midrst_outs: got h=%b ie=%b fv=%b sr=%0d sq=%b bp=%b expected all 0", halted, illegal_err, free_valid, store_release, squash, bp_valid); end
  endtask

  task automatic test_squash_halt();
    set_lane(0, 0, 0, 0, 0, 1, 0, 5'd2, 6'd46, 32'h80, 32'h2000);
    set_lane(1, 1, 0, 0, 0, 0, 0, 5'd9, 6'd47, 32'h84, 32'h88);
    step();
    tests_run++; if (squash !== 1'b0 || halted !== 1'b1) begin failed++; $display("FAIL sqhalt: got sq=%b h=%b expected 0/1", squash, halted); end
    tests_run++; if (retired_cnt !== 64'd1 || rrat(2) !== 6'd46 || rrat(9) !== 6'd9) begin failed++; $display("FAIL sqhalt_commit: got cnt=%0d r2=%0d r9=%0d expected 1/46/9", retired_cnt, rrat(2), rrat(9)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_waw();
    test_mispredict();
    test_gap();
    test_arn0_store();
    test_bp_oldest();
    test_halt();
    test_illegal();
    test_mid_reset();
    test_squash_halt();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/commit_stage.md
Name: commit_stage

Overview:
- Retirement stage directly downstream of the reorder buffer.
- Consumes up to N in-order commit lanes per cycle and maintains the retirement register alias table (RRAT, arch->phys map).
- Returns superseded physical registers to the free list, releases committed stores, and issues branch-predictor updates.
- Turns a mispredicted commit into a registered squash/redirect, and runs the halt/exception state machine.

Parameters:
- N, 2, commit width (lanes per cycle)
- ARCH_REGS, 32, architectural registers; arn 0 is hardwired zero
- PHYS_REGS, 64, physical registers
- XLEN, 32, PC/target width
- CNT_W, 64, retired-instruction counter width

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- ct_valid  in  N  lane i holds an executed ROB head entry
- ct_success  in  N  0 = mispredicted control op
- ct_is_store  in  N  lane is a store
- ct_is_branch  in  N  lane is a conditional or unconditional branch
- ct_taken  in  N  resolved direction
- ct_halt  in  N  halt instruction
- ct_illegal  in  N  illegal instruction
- ct_dest_arn  in  N*log2(ARCH_REGS)  destination arch reg
- ct_dest_prn  in  N*log2(PHYS_REGS)  destination phys reg
- ct_pc  in  N*XLEN  instruction PC
- ct_target  in  N*XLEN  resolved next PC
- free_valid  out  N  free_prn[i] is released this cycle
- free_prn  out  N*log2(PHYS_REGS)  superseded phys reg
- store_release  out  log2(N)+1  count of stores committed
- bp_valid  out  1  predictor update valid (oldest committed branch)
- bp_pc  out  XLEN  branch PC
- bp_taken  out  1  resolved direction
- bp_target  out  XLEN  resolved target
- squash  out  1  flush pipeline
- redirect_pc  out  XLEN  fetch restart PC, valid with squash
- rrat_map  out  ARCH_REGS*log2(PHYS_REGS)  committed map, used for rename recovery on squash
- retired_cnt  out  CNT_W  instructions retired
- halted  out  1  sticky halt
- illegal_err  out  1  halted due to illegal instruction

Behaviour:
- Reset: RRAT[a] = a for every a; all outputs 0; FSM = RUN; retired_cnt = 0.
- All outputs registered; one-cycle latency from ct_* to outputs.
- Lane acceptance: lane i is accepted iff ct_valid[i], lanes 0..i-1 accepted, no earlier accepted lane terminated the bundle, and FSM = RUN. Non-contiguous valid bits beyond the first gap are ignored.
- Terminating lanes:
  - ct_success = 0: lane commits; squash = 1 and redirect_pc = its ct_target next cycle; later lanes dropped.
  - halt or illegal: lane commits; FSM -> HALTED; later lanes dropped.
- Rename update per accepted lane with arn != 0:
  - old = current map of arn, including earlier lanes of the same bundle (same-bundle WAW chains: lane 1 frees lane 0's prn).
  - Output free_prn = old with free_valid = 1; RRAT[arn] <= prn, last lane wins.
  - arn = 0: no update, free_valid = 0.
- store_release = number of accepted lanes with ct_is_store.
- bp_*: oldest accepted lane with ct_is_branch; bp_valid = 0 if none.
- retired_cnt += number of accepted lanes; wraps modulo 2^CNT_W.
- rrat_map reflects RRAT after this cycle's updates, so it is valid in the same cycle as squash.
- FSM:
  - RUN -> HALTED on accepted halt/illegal.
  - HALTED is absorbing until reset; accepts nothing; outputs free/store/bp/squash held at 0.
  - halted = 1 from the cycle after the halt commits; illegal_err = 1 if the cause was illegal.
- Squash does not change FSM; input lanes arriving in the cycle after squash are accepted normally (ROB is responsible for being empty).
- Squash and halt in the same lane: halt takes priority; squash = 0.
- Reset mid-operation: the next cycle equals the reset state, regardless of pending lanes.

Test Plan:
- Post-reset: rrat_map[5] = 5, halted = 0. Commit lane0 arn=5 prn=40 -> next cycle free_valid=01, free_prn[0]=5, rrat_map[5]=40, retired_cnt=1.
- Same-bundle WAW: lane0 arn=3 prn=33, lane1 arn=3 prn=34 -> free_prn = {33, 3}, rrat_map[3]=34, retired_cnt += 2.
- Mispredict in lane0 (success=0, target=0x1000) with valid lane1 -> squash=1, redirect_pc=0x1000, lane1 not retired (retired_cnt += 1), lane1 RRAT untouched.
- arn=0 commit plus store in lane1 -> free_valid=00, store_release=1, rrat_map unchanged.
- Halt in lane0, store in lane1 -> halted=1, store_release=0, retired_cnt += 1; further valid lanes produce no outputs until reset, then RRAT returns to identity.
- Illegal in lane1 after a branch in lane0 (taken, pc=0x20) -> bp_valid=1, bp_pc=0x20, halted=1, illegal_err=1.
